// File: rtl/des_key_pkg.sv
// Shared DES key-schedule tables, permutation/rotation helpers and FSM state type.
package des_key_pkg;

    localparam int unsigned KEY_W    = 64;
    localparam int unsigned CD_W     = 56;
    localparam int unsigned HALF_W   = 28;
    localparam int unsigned SUBKEY_W = 48;

    localparam logic [15:0] DES_SHIFT_MASK = 16'h8103;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Entries are 1-based bit numbers, bit 1 = MSB of the source word.
    localparam int unsigned PC1_TABLE [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int unsigned PC2_TABLE [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        cd = '0;
        for (int i = 0; i < 56; i++) begin
            cd[6'(55 - i)] = key[6'(64 - PC1_TABLE[i])];
        end
        return cd;
    endfunction

    function automatic logic [SUBKEY_W-1:0] pc2(input logic [CD_W-1:0] cd);
        logic [SUBKEY_W-1:0] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[6'(47 - i)] = cd[6'(56 - PC2_TABLE[i])];
        end
        return k;
    endfunction

    // Valid for n in 0..28.
    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                 input int unsigned n);
        logic [2*HALF_W-1:0] t;
        t = {x, x} << n;
        return t[2*HALF_W-1:HALF_W];
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                 input int unsigned n);
        logic [2*HALF_W-1:0] t;
        t = {x, x} >> n;
        return t[HALF_W-1:0];
    endfunction

    // r is the 1-based round number.
    function automatic int unsigned shift_amt(input logic [15:0] mask, input int unsigned r);
        return mask[4'(r - 1)] ? 32'd1 : 32'd2;
    endfunction

    function automatic int unsigned total_shift(input logic [15:0] mask, input int unsigned rounds);
        int unsigned s;
        s = 0;
        for (int unsigned r = 1; r <= rounds; r++) begin
            s += shift_amt(mask, r);
        end
        return s;
    endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// Combinational C/D half rotator: each 28-bit half rotates independently by 1 or 2.
module des_cd_rotator
    import des_key_pkg::*;
(
    input  logic [HALF_W-1:0] c_i,
    input  logic [HALF_W-1:0] d_i,
    input  logic              dir_right_i,
    input  logic              shift_two_i,
    output logic [HALF_W-1:0] c_o,
    output logic [HALF_W-1:0] d_o
);

    int unsigned amt;

    always_comb begin
        amt = shift_two_i ? 32'd2 : 32'd1;
        c_o = rotl28(c_i, amt);
        d_o = rotl28(d_i, amt);
        if (dir_right_i) begin
            c_o = rotr28(c_i, amt);
            d_o = rotr28(d_i, amt);
        end
    end

endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: loads one key, streams ROUNDS subkeys through a
// single shared PC-2, in encrypt (K1..KN) or decrypt (KN..K1) order.
module des_key_scheduler
    import des_key_pkg::*;
#(
    parameter int unsigned ROUNDS     = 16,
    parameter logic [15:0] SHIFT_MASK = DES_SHIFT_MASK,
    parameter int unsigned RW         = $clog2(ROUNDS + 1)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                keyValid,
    output logic                keyReady,
    input  logic [KEY_W-1:0]    keyIn,
    input  logic                decrypt,
    output logic                subKeyValid,
    input  logic                subKeyReady,
    output logic [SUBKEY_W-1:0] subKey,
    output logic [RW-1:0]       roundNum,
    output logic                busy
);

    // Decrypt starts from the fully rotated state, which equals the state of the last round.
    localparam int unsigned TOTAL_ROT = total_shift(SHIFT_MASK, ROUNDS) % HALF_W;
    localparam int unsigned ENC_ROT   = shift_amt(SHIFT_MASK, 1);

    state_e            state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d, d_q, d_d;
    logic [RW-1:0]     round_q, round_d;
    logic              mode_q, mode_d;

    logic [CD_W-1:0]   pc1_c;
    logic [HALF_W-1:0] c_load_c, d_load_c, c_rot_c, d_rot_c;
    logic [3:0]        mask_idx_c;
    logic              shift_two_c, last_c, run_c, load_c;

    // Next round's shift: encrypt uses shift(round+1), decrypt undoes shift(ROUNDS+1-round).
    always_comb begin
        mask_idx_c  = mode_q ? 4'(RW'(ROUNDS) - round_q) : 4'(round_q);
        shift_two_c = ~SHIFT_MASK[mask_idx_c];
    end

    des_cd_rotator u_rot (
        .c_i         (c_q),
        .d_i         (d_q),
        .dir_right_i (mode_q),
        .shift_two_i (shift_two_c),
        .c_o         (c_rot_c),
        .d_o         (d_rot_c)
    );

    always_comb begin
        pc1_c    = pc1(keyIn);
        c_load_c = rotl28(pc1_c[CD_W-1:HALF_W], ENC_ROT);
        d_load_c = rotl28(pc1_c[HALF_W-1:0], ENC_ROT);
        if (decrypt) begin
            c_load_c = rotl28(pc1_c[CD_W-1:HALF_W], TOTAL_ROT);
            d_load_c = rotl28(pc1_c[HALF_W-1:0], TOTAL_ROT);
        end
    end

    // Next-state and outputs; subKeyReady -> keyReady is a deliberate combinational path.
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        d_d         = d_q;
        round_d     = round_q;
        mode_d      = mode_q;
        run_c       = (state_q == RUN);
        last_c      = (round_q == RW'(ROUNDS));
        keyReady    = reset_n && (!run_c || (last_c && subKeyReady));
        load_c      = keyValid && keyReady;
        subKeyValid = run_c;
        busy        = run_c;
        subKey      = pc2({c_q, d_q});
        roundNum    = '0;

        if (run_c) begin
            roundNum = mode_q ? (RW'(ROUNDS + 1) - round_q) : round_q;
        end

        if (run_c && subKeyReady) begin
            if (last_c) begin
                state_d = IDLE;
            end else begin
                round_d = round_q + RW'(1);
                c_d     = c_rot_c;
                d_d     = d_rot_c;
            end
        end

        if (load_c) begin
            state_d = RUN;
            mode_d  = decrypt;
            round_d = RW'(1);
            c_d     = c_load_c;
            d_d     = d_load_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            mode_q  <= mode_d;
        end
    end

endmodule
